decode_execute_pipe: RTL and testbench

DECODE_EXECUTE_PIPE -- requirements
Module: decode_execute_pipe

---
 rtl/decode_execute_pipe.sv | 119 +++++++++++
 tb/tb_decode_execute_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_pipe.sv
// Two-stage decode/execute pipeline with valid/ready handshakes on both sides.
// S1 holds the decoded operation, S2 holds the registered result and flags.

module decode_execute_alu #(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] rd,
    output logic             carry
);
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] gt_mask;

    assign add_w = {1'b0, rs} + {1'b0, rt};
    assign sub_w = {1'b0, rs} + {1'b0, ~rt} + {{WIDTH{1'b0}}, 1'b1};

    // GT fills the upper bits with an alternating pattern anchored at the MSB
    assign gt_mask[0] = 1'b0;
    for (genvar i = 1; i < WIDTH; i++) begin : g_gt
        assign gt_mask[i] = (((WIDTH - 1 - i) % 2) == 0);
    end

    always_comb begin
        rd    = '0;
        carry = 1'b0;
        case (sel)
            3'd0: {carry, rd} = add_w;
            3'd1: {carry, rd} = sub_w;
            3'd2: rd = rs & rt;
            3'd3: rd = rs | rt;
            3'd4: rd = {rs[WIDTH-2:0], rs[WIDTH-1]};
            3'd5: rd = {rt[WIDTH-1], rt[WIDTH-1:1]};
            3'd6: rd = {{(WIDTH-1){1'b1}}, rs == rt};
            3'd7: rd = gt_mask | {{(WIDTH-1){1'b0}}, rs > rt};
            default: rd = '0;
        endcase
    end
endmodule

module decode_execute_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             out_carry,
    output logic             out_zero
);
    typedef struct packed {
        logic [2:0]       sel;
        logic [WIDTH-1:0] rs;
        logic [WIDTH-1:0] rt;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] rd;
        logic             carry;
        logic             zero;
    } rsp_t;

    logic [2:1]       vld_pipe;
    req_t             s1;
    rsp_t             s2;
    rsp_t             rsp_next;
    logic [WIDTH-1:0] alu_rd;
    logic             alu_carry;
    logic             s2_load;
    logic             in_fire;

    decode_execute_alu #(.WIDTH(WIDTH)) u_alu (
        .sel   (s1.sel),
        .rs    (s1.rs),
        .rt    (s1.rt),
        .rd    (alu_rd),
        .carry (alu_carry)
    );

    assign rsp_next = '{rd: alu_rd, carry: alu_carry, zero: (alu_rd == '0)};

    // S2 frees up whenever it is empty or being drained this cycle
    assign s2_load  = !vld_pipe[2] || out_ready;
    assign in_ready = rst || !vld_pipe[1] || !vld_pipe[2] || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            if (in_fire) begin
                s1          <= '{sel: sel, rs: rs, rt: rt};
                vld_pipe[1] <= 1'b1;
            end else if (s2_load) begin
                vld_pipe[1] <= 1'b0;
            end
            if (s2_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1])
                    s2 <= rsp_next;
            end
        end
    end

    assign out_valid = vld_pipe[2];
    assign rd        = s2.rd;
    assign out_carry = s2.carry;
    assign out_zero  = s2.zero;
endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed bench: WIDTH=4 handshake/latency/reset checks plus a WIDTH=8 opcode sweep.

module tb_decode_execute_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       iv4, ir4, ov4, ordy4, c4, z4;
    logic [3:0] rs4, rt4, rd4;
    logic [2:0] sel4;
    logic       iv8, ir8, ov8, ordy8, c8, z8;
    logic [7:0] rs8, rt8, rd8;
    logic [2:0] sel8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_execute_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .rs(rs4), .rt(rt4),
        .sel(sel4), .out_valid(ov4), .out_ready(ordy4), .rd(rd4),
        .out_carry(c4), .out_zero(z4)
    );

    decode_execute_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .rs(rs8), .rt(rt8),
        .sel(sel8), .out_valid(ov8), .out_ready(ordy8), .rd(rd8),
        .out_carry(c8), .out_zero(z8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hand-computed WIDTH=4 vectors: sel, rs, rt -> rd, carry, zero
    logic [2:0] t_sel [10];
    logic [3:0] t_rs  [10];
    logic [3:0] t_rt  [10];
    logic [3:0] t_rd  [10];
    logic       t_c   [10];
    logic       t_z   [10];

    task automatic set_vec(input int i, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] r, input logic c, input logic z);
        t_sel[i] = s; t_rs[i] = a; t_rt[i] = b; t_rd[i] = r; t_c[i] = c; t_z[i] = z;
    endtask

    task automatic run4(input string tag, input int i);
        sel4 = t_sel[i]; rs4 = t_rs[i]; rt4 = t_rt[i]; iv4 = 1'b1; ordy4 = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(ir4), 32'd1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        chk({tag, "_lat1"}, 32'(ov4), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(ov4), 32'd1);
        chk({tag, "_rd"}, 32'(rd4), 32'(t_rd[i]));
        chk({tag, "_c"}, 32'(c4), 32'(t_c[i]));
        chk({tag, "_z"}, 32'(z4), 32'(t_z[i]));
        @(posedge clk); #1;
        chk({tag, "_drain"}, 32'(ov4), 32'd0);
    endtask

    function automatic logic [9:0] model8(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       c;
        logic [8:0] t;
        r = '0; c = 1'b0;
        case (s)
            3'd0: begin t = 9'(a) + 9'(b); r = t[7:0]; c = t[8]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = {a[6:0], a[7]};
            3'd5: r = $signed(b) >>> 1;
            3'd6: r = 8'hFE | {7'b0, a == b};
            3'd7: r = 8'hAA | {7'b0, a > b};
            default: r = '0;
        endcase
        return {r, c, r == 8'h00};
    endfunction

    task automatic run8(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [9:0] e;
        string      tag;
        e = model8(s, a, b);
        tag = $sformatf("w8_op%0d_%02h_%02h", s, a, b);
        sel8 = s; rs8 = a; rt8 = b; iv8 = 1'b1; ordy8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(ov8), 32'd1);
        chk({tag, "_rd"}, 32'(rd8), 32'(e[9:2]));
        chk({tag, "_c"}, 32'(c8), 32'(e[1]));
        chk({tag, "_z"}, 32'(z8), 32'(e[0]));
        @(posedge clk); #1;
    endtask

    initial begin
        int         idx_in, idx_out;
        logic       saw_full, stalled_prev, fire_in, fire_out;
        logic [3:0] prev_rd;
        logic [7:0] a, b;

        set_vec(0, 3'd0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0);  // ADD
        set_vec(1, 3'd1, 4'h3, 4'h3, 4'h0, 1'b1, 1'b1);  // SUB equal
        set_vec(2, 3'd1, 4'h2, 4'h5, 4'hD, 1'b0, 1'b0);  // SUB borrow
        set_vec(3, 3'd4, 4'h9, 4'h0, 4'h3, 1'b0, 1'b0);  // ROL
        set_vec(4, 3'd5, 4'h0, 4'hA, 4'hD, 1'b0, 1'b0);  // ASR
        set_vec(5, 3'd6, 4'h7, 4'h7, 4'hF, 1'b0, 1'b0);  // EQ
        set_vec(6, 3'd7, 4'h5, 4'h3, 4'hB, 1'b0, 1'b0);  // GT true
        set_vec(7, 3'd7, 4'h3, 4'h5, 4'hA, 1'b0, 1'b0);  // GT false
        set_vec(8, 3'd2, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0);  // AND
        set_vec(9, 3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1);  // ADD wrap to zero

        rst = 1'b1; iv4 = 1'b0; ordy4 = 1'b1; rs4 = '0; rt4 = '0; sel4 = '0;
        iv8 = 1'b0; ordy8 = 1'b1; rs8 = '0; rt8 = '0; sel8 = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ov", 32'(ov4), 32'd0);
        chk("rst_rd", 32'(rd4), 32'd0);
        chk("rst_c", 32'(c4), 32'd0);
        chk("rst_z", 32'(z4), 32'd0);
        chk("rst_ir", 32'(ir4), 32'd1);
        chk("rst_ov8", 32'(ov8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run4($sformatf("dir%0d", i), i);

        // streaming with a 3-cycle consumer stall in the middle
        idx_in = 0; idx_out = 0; saw_full = 1'b0; stalled_prev = 1'b0; prev_rd = '0;
        for (int cyc = 0; cyc < 60 && idx_out < 8; cyc++) begin
            if (stalled_prev) begin
                chk($sformatf("stall_ov%0d", cyc), 32'(ov4), 32'd1);
                chk($sformatf("stall_rd%0d", cyc), 32'(rd4), 32'(prev_rd));
            end
            ordy4 = !(cyc >= 3 && cyc < 6);
            iv4 = (idx_in < 8);
            if (idx_in < 8) begin
                sel4 = t_sel[idx_in]; rs4 = t_rs[idx_in]; rt4 = t_rt[idx_in];
            end
            #1;
            if (!ir4) saw_full = 1'b1;
            fire_in  = iv4 && ir4;
            fire_out = ov4 && ordy4;
            stalled_prev = ov4 && !ordy4;
            prev_rd = rd4;
            if (fire_out) begin
                chk($sformatf("strm%0d_rd", idx_out), 32'(rd4), 32'(t_rd[idx_out]));
                chk($sformatf("strm%0d_c", idx_out), 32'(c4), 32'(t_c[idx_out]));
                chk($sformatf("strm%0d_z", idx_out), 32'(z4), 32'(t_z[idx_out]));
                idx_out++;
            end
            @(posedge clk); #1;
            if (fire_in) idx_in++;
        end
        iv4 = 1'b0; ordy4 = 1'b1;
        chk("strm_count", 32'(idx_out), 32'd8);
        chk("strm_full_seen", 32'(saw_full), 32'd1);
        chk("strm_nodup", 32'(ov4), 32'd0);
        @(posedge clk); #1;

        // fill both stages, then reset with a new op presented
        ordy4 = 1'b0; iv4 = 1'b1; sel4 = 3'd0; rs4 = 4'h1; rt4 = 4'h1;
        @(posedge clk); #1;
        rs4 = 4'h2;
        @(posedge clk); #1;
        chk("full_ir", 32'(ir4), 32'd0);
        chk("full_ov", 32'(ov4), 32'd1);
        rs4 = 4'h4; rt4 = 4'h4; rst = 1'b1;
        #1;
        chk("rsthi_ir", 32'(ir4), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; iv4 = 1'b0;
        chk("midrst_ov", 32'(ov4), 32'd0);
        chk("midrst_rd", 32'(rd4), 32'd0);
        chk("midrst_c", 32'(c4), 32'd0);
        chk("midrst_z", 32'(z4), 32'd0);
        ordy4 = 1'b1;
        @(posedge clk); #1;
        chk("postrst_idle1", 32'(ov4), 32'd0);
        @(posedge clk); #1;
        chk("postrst_idle2", 32'(ov4), 32'd0);
        run4("postrst", 5);

        // WIDTH=8 sweep including rs==rt, rt==0 and rs==FF
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 5; k++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                case (k)
                    1: b = a;
                    2: b = 8'h00;
                    3: a = 8'hFF;
                    4: begin a = 8'hFF; b = 8'hFF; end
                    default: ;
                endcase
                run8(3'(s), a, b);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
